// File: rtl/msk_prng_pkg.sv
// Shared definitions for the masked-gadget randomness source.
//   - prng_state_e : controller states (IDLE, LOAD, WARMUP, RUN)
//   - LFSR_W, SEED_WORDS, LFSR_FALLBACK : generator geometry and zero-seed substitute
//   - TAP0..TAP3 : Fibonacci feedback taps of the 128-bit LFSR
//   - rnd_width(d) : fresh bits per cycle needed by a d-share gadget
package msk_prng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } prng_state_e;

    localparam int LFSR_W     = 128;
    localparam int SEED_WORDS = 4;

    localparam int TAP0 = 127;
    localparam int TAP1 = 125;
    localparam int TAP2 = 100;
    localparam int TAP3 = 98;

    // All-zero is the LFSR's lock-up state, so a zero seed is replaced by this.
    localparam logic [LFSR_W-1:0] LFSR_FALLBACK = 128'h1;

    function automatic int rnd_width(input int d);
        return d * (d - 1);
    endfunction

endpackage

// File: rtl/msk_lfsr_step.sv
// N unrolled Fibonacci steps of the 128-bit LFSR, purely combinational.
//   state_i : current LFSR state
//   state_o : state after N steps; each step shifts left and inserts
//             s[127]^s[125]^s[100]^s[98] at bit 0
module msk_lfsr_step
    import msk_prng_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] chain [0:N];

    assign chain[0] = state_i;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_step
            assign chain[gi+1] = {chain[gi][LFSR_W-2:0],
                                  chain[gi][TAP0] ^ chain[gi][TAP1] ^
                                  chain[gi][TAP2] ^ chain[gi][TAP3]};
        end
    endgenerate

    assign state_o = chain[N];

endmodule

// File: rtl/msk_rnd_prng.sv
// Fresh-randomness source feeding the rnd input of a masked gadget.
// A 128-bit LFSR is seeded by four 32-bit words (word 0 = LSBs), warmed up
// for WARMUP discarded advances, then produces RND_W bits per enabled cycle.
//   clk, rst_n             : clock, asynchronous active-low reset
//   seed_in/valid/ready    : seed word handshake
//   en                     : advance generator and refresh rnd (RUN only)
//   rnd, rnd_valid         : registered random bits and freshness flag
//   busy                   : high while loading or warming up
module msk_rnd_prng
    import msk_prng_pkg::*;
#(
    parameter int d      = 2,
    parameter int RND_W  = rnd_width(d),
    parameter int WARMUP = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      seed_in,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             en,
    output logic [RND_W-1:0] rnd,
    output logic             rnd_valid,
    output logic             busy
);

    prng_state_e       state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [7:0]        wup_q, wup_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic              rnd_valid_q, rnd_valid_d;

    logic [LFSR_W-1:0] lfsr_adv;
    logic [LFSR_W-1:0] seed_full;
    logic              xfer;

    // One advance = RND_W steps; shared by warm-up and run.
    msk_lfsr_step #(.N(RND_W)) u_step (
        .state_i (lfsr_q),
        .state_o (lfsr_adv)
    );

    assign seed_ready = (state_q != ST_WARMUP);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_WARMUP);
    assign xfer       = seed_valid && seed_ready;
    // Complete state as it stands once the final word lands.
    assign seed_full  = {seed_in, lfsr_q[95:0]};

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        wcnt_d      = wcnt_q;
        wup_d       = wup_q;
        rnd_d       = rnd_q;
        rnd_valid_d = rnd_valid_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                // A new seed wins over en: write word 0, no advance.
                if (xfer) begin
                    lfsr_d[31:0] = seed_in;
                    wcnt_d       = 2'd1;
                    rnd_d        = '0;
                    rnd_valid_d  = 1'b0;
                    state_d      = ST_LOAD;
                end else if (state_q == ST_RUN && en) begin
                    lfsr_d      = lfsr_adv;
                    rnd_d       = lfsr_adv[RND_W-1:0];
                    rnd_valid_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    lfsr_d[{wcnt_q, 5'b0} +: 32] = seed_in;
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'(SEED_WORDS - 1)) begin
                        lfsr_d  = (seed_full == '0) ? LFSR_FALLBACK : seed_full;
                        wup_d   = 8'(WARMUP);
                        state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                    end
                end
            end
            ST_WARMUP: begin
                lfsr_d = lfsr_adv;
                wup_d  = wup_q - 8'd1;
                if (wup_q == 8'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= '0;
            wcnt_q      <= '0;
            wup_q       <= '0;
            rnd_q       <= '0;
            rnd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            wcnt_q      <= wcnt_d;
            wup_q       <= wup_d;
            rnd_q       <= rnd_d;
            rnd_valid_q <= rnd_valid_d;
        end
    end

    assign rnd       = rnd_q;
    assign rnd_valid = rnd_valid_q;

endmodule

// File: doc/msk_rnd_prng.md
# msk_rnd_prng

Fresh-randomness source for masked gadgets such as the HPC3 AND and its cross-domain variant. It sits directly upstream of the gadget's `rnd` input and delivers `RND_W = d*(d-1)` pseudo-random bits per enabled cycle from a seeded 128-bit LFSR. Seeding is a 32-bit word handshake followed by a fixed warm-up. Re-seeding is allowed at any time.

## Interface
- `d`, default 2: number of shares of the consuming gadget; legal range 2..11.
- `RND_W`, default `d*(d-1)`: random bits per cycle; must be ≤ 128; do not override.
- `WARMUP`, default 128: output-discard cycles after seeding; range 0..255.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `seed_in`  in  32: seed word.
- `seed_valid`  in  1: seed word present.
- `seed_ready`  out  1: block accepts a seed word.
- `en`  in  1: advance generator and refresh `rnd`.
- `rnd`  out  `RND_W`: random bits to the gadget; registered.
- `rnd_valid`  out  1: `rnd` is fresh post-warm-up output.
- `busy`  out  1: high in LOAD or WARMUP.

## Operation
- FSM states:
  - IDLE: `seed_ready=1`.
  - LOAD: `seed_ready=1`; 2-bit word counter.
  - WARMUP: 8-bit down-counter.
  - RUN: `seed_ready=1`.
- Word transfer occurs when `seed_valid & seed_ready` at a rising edge.
  - Word k (0..3) loads state bits `[32k+31:32k]`; word 0 is LSB.
- IDLE or RUN + transfer: word counter set to 1 and word 0 is written.
  - Go to LOAD.
  - `rnd_valid` drops on the same edge.
- LOAD + transfer of word 3:
  - If the assembled 128-bit state is all-zero, load the fallback constant `128'h1` instead.
  - Go to WARMUP with counter = `WARMUP`, or go directly to RUN if `WARMUP=0`.
- LOAD without `seed_valid`: hold; no timeout.
- LFSR step (Fibonacci):
  - feedback `f = s[127]^s[125]^s[100]^s[98]`
  - `s' = {s[126:0], f}`
- One "advance" equals `RND_W` consecutive steps, computed combinationally in one cycle.
- WARMUP:
  - Each cycle, advance the state regardless of `en` and decrement the counter.
  - When the counter reaches 0, go to RUN.
  - `rnd` is held at 0.
- RUN with `en=1`:
  - Advance the state.
  - `rnd <= low RND_W bits of the advanced state`.
  - `rnd_valid <= 1`.
- RUN with `en=0`: state and `rnd` are held; `rnd_valid` is unchanged.
- In RUN, a seed transfer takes priority over `en`: the first word is written and no advance occurs.
- `busy = (state==LOAD) | (state==WARMUP)`, decoded combinationally from registered state.

## Timing
- Reset values (asynchronous, immediate on `rst_n=0`):
  - FSM = IDLE
  - LFSR = 0
  - `rnd = 0`
  - `rnd_valid = 0`
  - `seed_ready = 1`
  - `busy = 0`
- Seeding takes 4 transfer cycles, minimum 4 consecutive edges.
- Warm-up takes exactly `WARMUP` edges after the word-3 edge.
- First valid output:
  - The first RUN edge with `en=1` updates `rnd`.
  - `rnd_valid` rises on that same edge.
  - Minimum latency from word 0: 4 + `WARMUP` + 1 edges.
- `rnd` changes only on an enabled RUN edge. The gadget samples `rnd` in the cycle after `en`.
- Reset asserted mid-LOAD or mid-WARMUP: all partial seed is discarded; the FSM returns to IDLE.
- `en` in IDLE, LOAD or WARMUP is ignored.
- Words arriving while in WARMUP are not accepted, since `seed_ready=0` there.

## Structure
- Package `msk_prng_pkg` contains:
  - the FSM state enum
  - tap positions `{127,125,100,98}`
  - `LFSR_W=128`, `SEED_WORDS=4`, the fallback constant
  - function `rnd_width(d) = d*(d-1)`
- Sub-module `msk_lfsr_step`: purely combinational, parameter `N`, 128-bit in and out. It computes N unrolled Fibonacci steps and is used for both WARMUP and RUN advances.
- Top level contains the FSM, counters, seed assembly and the output register.

## Test plan
- **Reset:** assert `rst_n=0` mid-operation → same cycle `rnd=0`, `rnd_valid=0`, `seed_ready=1`, `busy=0`.
- **Zero-seed guard:** `d=2`, `WARMUP=0`, four words of 0 → state `128'h1`. One `en` cycle → state `128'h4`, `rnd=2'b00`, `rnd_valid=1`. Continue against the golden model.
- **Latency:** `WARMUP=4`, seed `32'hDEADBEEF` ×4 back-to-back, `en` held high → `busy` high for 8 edges; `rnd_valid` rises on edge 9 after word 0; `rnd` matches the model for 100 cycles.
- **Hold:** in RUN toggle `en` 1,0,0,1 → `rnd` unchanged during the `en=0` cycles. The sequence equals the model with no skipped advances.
- **Reseed mid-run:** `seed_valid` with `en=1` in RUN → word 0 accepted and no advance. `rnd_valid=0` next edge, `busy=1`. After re-seed and warm-up, output matches a fresh model.
- **Reset mid-WARMUP, then seeding stall:** pulse `rst_n` during WARMUP → IDLE. Send 2 words, deassert `seed_valid` for 10 cycles, then 2 more → state assembled correctly in word order.
